// File: rtl/debug_slave_sysclk_bridge.sv
// debug_slave_sysclk_bridge
//   System-clock side of the JTAG debug slave. The TCK-domain update levels
//   (vs_uir / vs_udr) are resynchronised into clk, and a rising edge of each is
//   detected. On an IR update the virtual IR is captured. On a DR update the
//   scanned shift register is captured into jdo, and a one-hot take_action or
//   take_no_action strobe is raised on the channel selected by ir_in.
//   With HANDSHAKE=1 the command is held until act_ready is seen. A DR update
//   that arrives while a command is held and not being accepted is an overrun.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   vs_udr, vs_uir        update-DR / update-IR levels from the TCK domain (async)
//   ir_in [IR_W]          virtual IR, quasi-static around updates
//   sr [SR_W]             scanned shift register, quasi-static around updates
//   act_ready             consumer accepts the held command (HANDSHAKE=1)
//   clr_overrun           clears overrun and overrun_cnt
//   jdo [SR_W]            captured sr
//   ir_q [IR_W]           IR captured on the last UIR
//   update_ir             one-cycle pulse after each UIR
//   take_action [2**IR_W] one-hot strobe, sr[ACT_BIT]=1
//   take_no_action        one-hot strobe, sr[ACT_BIT]=0
//   busy                  command held (HANDSHAKE=1 only)
//   overrun               sticky overrun flag
//   overrun_cnt [CNT_W]   saturating overrun count
module debug_slave_sysclk_bridge #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int ACT_BIT     = 34,
  parameter int SYNC_STAGES = 2,
  parameter int HANDSHAKE   = 0,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [SR_W-1:0]        sr,
  input  logic                   act_ready,
  input  logic                   clr_overrun,
  output logic [SR_W-1:0]        jdo,
  output logic [IR_W-1:0]        ir_q,
  output logic                   update_ir,
  output logic [(2**IR_W)-1:0]   take_action,
  output logic [(2**IR_W)-1:0]   take_no_action,
  output logic                   busy,
  output logic                   overrun,
  output logic [CNT_W-1:0]       overrun_cnt
);

  localparam int NCH = 2**IR_W;

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_edge_q, uir_edge_q;
  logic                   udr_rise, uir_rise;
  state_e                 state_q, state_d;
  logic [SR_W-1:0]        jdo_q, jdo_d;
  logic [IR_W-1:0]        ir_reg_q, ir_reg_d;
  logic                   update_ir_q, update_ir_d;
  logic [NCH-1:0]         act_q, act_d, noact_q, noact_d;
  logic [NCH-1:0]         dec_act, dec_noact;
  logic                   overrun_q, overrun_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovr_evt;

  // ---- synchroniser stages and edge flops ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_edge_q <= 1'b0;
      uir_edge_q <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_edge_q <= udr_sync_q[SYNC_STAGES-1];
      uir_edge_q <= uir_sync_q[SYNC_STAGES-1];
    end
  end

  // ---- rise detect, IR decode, command FSM ----
  assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;
  assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;

  always_comb begin
    dec_act   = '0;
    dec_noact = '0;
    if (sr[ACT_BIT]) dec_act[ir_in]   = 1'b1;
    else             dec_noact[ir_in] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    jdo_d       = jdo_q;
    act_d       = act_q;
    noact_d     = noact_q;
    ir_reg_d    = ir_reg_q;
    update_ir_d = uir_rise;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;
    ovr_evt     = 1'b0;

    if (uir_rise) ir_reg_d = ir_in;

    if (HANDSHAKE == 0) begin
      state_d = S_IDLE;
      act_d   = '0;
      noact_d = '0;
      if (udr_rise) begin
        jdo_d   = sr;
        act_d   = dec_act;
        noact_d = dec_noact;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (udr_rise) begin
            state_d = S_HOLD;
            jdo_d   = sr;
            act_d   = dec_act;
            noact_d = dec_noact;
          end
        end
        S_HOLD: begin
          if (act_ready) begin
            // Accepting the old command frees the slot for a same-cycle new one.
            if (udr_rise) begin
              jdo_d   = sr;
              act_d   = dec_act;
              noact_d = dec_noact;
            end else begin
              state_d = S_IDLE;
              act_d   = '0;
              noact_d = '0;
            end
          end else if (udr_rise) begin
            ovr_evt = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A clear coinciding with a fresh overrun leaves that overrun recorded.
    if (clr_overrun) begin
      overrun_d = ovr_evt;
      cnt_d     = ovr_evt ? CNT_W'(1) : '0;
    end else if (ovr_evt) begin
      overrun_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---- output registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      jdo_q       <= '0;
      ir_reg_q    <= '0;
      update_ir_q <= 1'b0;
      act_q       <= '0;
      noact_q     <= '0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      jdo_q       <= jdo_d;
      ir_reg_q    <= ir_reg_d;
      update_ir_q <= update_ir_d;
      act_q       <= act_d;
      noact_q     <= noact_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  assign jdo            = jdo_q;
  assign ir_q           = ir_reg_q;
  assign update_ir      = update_ir_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign busy           = (state_q == S_HOLD);
  assign overrun        = overrun_q;
  assign overrun_cnt    = cnt_q;

endmodule

// File: tb/tb_debug_slave_sysclk_bridge.sv
module tb_debug_slave_sysclk_bridge;

  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int NCH  = 4;
  localparam int ACT  = 34;
  localparam int S    = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            vs_udr, vs_uir;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            act_ready, clr_overrun;

  logic [SR_W-1:0] p_jdo, h_jdo;
  logic [IR_W-1:0] p_irq, h_irq;
  logic            p_upd, h_upd;
  logic [NCH-1:0]  p_ta, p_tna, h_ta, h_tna;
  logic            p_busy, h_busy, p_ovr, h_ovr;
  logic [7:0]      p_cnt;
  logic [1:0]      h_cnt;

  always #5 clk = ~clk;

  debug_slave_sysclk_bridge #(.SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(ACT), .SYNC_STAGES(S),
                              .HANDSHAKE(0), .CNT_W(8)) dut_p (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .act_ready(act_ready), .clr_overrun(clr_overrun), .jdo(p_jdo), .ir_q(p_irq),
    .update_ir(p_upd), .take_action(p_ta), .take_no_action(p_tna), .busy(p_busy),
    .overrun(p_ovr), .overrun_cnt(p_cnt));

  debug_slave_sysclk_bridge #(.SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(ACT), .SYNC_STAGES(S),
                              .HANDSHAKE(1), .CNT_W(2)) dut_h (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .act_ready(act_ready), .clr_overrun(clr_overrun), .jdo(h_jdo), .ir_q(h_irq),
    .update_ir(h_upd), .take_action(h_ta), .take_no_action(h_tna), .busy(h_busy),
    .overrun(h_ovr), .overrun_cnt(h_cnt));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: input history per clock edge, plus the architectural outputs.
  bit              udr_h[0:7];
  bit              uir_h[0:7];
  logic [SR_W-1:0] m_jdo_p, m_jdo_h;
  logic [IR_W-1:0] m_irq;
  bit              m_upd, m_hold, m_ovr;
  logic [NCH-1:0]  m_ta_p, m_tna_p, m_ta_h, m_tna_h;
  int              m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin udr_h[i] = 1'b0; uir_h[i] = 1'b0; end
    m_jdo_p = '0; m_jdo_h = '0; m_irq = '0; m_upd = 1'b0; m_hold = 1'b0; m_ovr = 1'b0;
    m_ta_p = '0; m_tna_p = '0; m_ta_h = '0; m_tna_h = '0; m_cnt = 0;
  endtask

  task automatic model_update();
    bit             urise, irise, ovr;
    logic [NCH-1:0] dta, dtna;
    if (!reset_n) begin model_reset(); return; end
    for (int i = 7; i > 0; i--) begin udr_h[i] = udr_h[i-1]; uir_h[i] = uir_h[i-1]; end
    udr_h[0] = vs_udr;
    uir_h[0] = vs_uir;
    // Level first seen at edge n-S produces a registered effect at edge n.
    urise = udr_h[S] && !udr_h[S+1];
    irise = uir_h[S] && !uir_h[S+1];
    dta  = sr[ACT] ? (NCH'(1) << ir_in) : '0;
    dtna = sr[ACT] ? '0 : (NCH'(1) << ir_in);

    m_upd = irise;
    if (irise) m_irq = ir_in;

    if (urise) begin m_jdo_p = sr; m_ta_p = dta; m_tna_p = dtna; end
    else begin m_ta_p = '0; m_tna_p = '0; end

    ovr = 1'b0;
    if (!m_hold) begin
      if (urise) begin m_hold = 1'b1; m_jdo_h = sr; m_ta_h = dta; m_tna_h = dtna; end
    end else if (act_ready && urise) begin
      m_jdo_h = sr; m_ta_h = dta; m_tna_h = dtna;
    end else if (act_ready) begin
      m_hold = 1'b0; m_ta_h = '0; m_tna_h = '0;
    end else if (urise) begin
      ovr = 1'b1;
    end
    if (clr_overrun) begin
      m_ovr = ovr; m_cnt = ovr ? 1 : 0;
    end else if (ovr) begin
      m_ovr = 1'b1;
      if (m_cnt < 3) m_cnt++;
    end
  endtask

  task automatic check_all();
    chk("p_jdo", p_jdo, m_jdo_p);     chk("h_jdo", h_jdo, m_jdo_h);
    chk("p_ir_q", p_irq, m_irq);      chk("h_ir_q", h_irq, m_irq);
    chk("p_update_ir", p_upd, m_upd); chk("h_update_ir", h_upd, m_upd);
    chk("p_take_action", p_ta, m_ta_p);      chk("p_take_no_action", p_tna, m_tna_p);
    chk("h_take_action", h_ta, m_ta_h);      chk("h_take_no_action", h_tna, m_tna_h);
    chk("p_busy", p_busy, 0);         chk("h_busy", h_busy, m_hold);
    chk("p_overrun", p_ovr, 0);       chk("h_overrun", h_ovr, m_ovr);
    chk("p_overrun_cnt", p_cnt, 0);   chk("h_overrun_cnt", h_cnt, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int pulses;
  int udr_run, uir_run;

  initial begin
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    act_ready = 1'b0; clr_overrun = 1'b0;
    model_reset();
    steps(3);
    reset_n = 1'b1;
    steps(3);

    // Pulse mode, action on channel 2 (bit 34 set).
    act_ready = 1'b1;
    ir_in = 2'd2; sr = 38'h2E_DEAD_BEEF; vs_udr = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (e == 2) begin
        chk("t2_take_action", p_ta, 4'b0100);
        chk("t2_jdo", p_jdo, 38'h2E_DEAD_BEEF);
      end else begin
        chk("t2_take_action_idle", p_ta, 4'b0000);
      end
    end
    vs_udr = 1'b0; steps(4);

    // 38'h2A_DEAD_BEEF has bit 34 clear -> no-action strobe on channel 2.
    sr = 38'h2A_DEAD_BEEF; vs_udr = 1'b1;
    steps(3);
    chk("t2b_take_no_action", p_tna, 4'b0100);
    chk("t2b_take_action", p_ta, 4'b0000);
    vs_udr = 1'b0; steps(4);

    // Pulse mode, no-action on channel 1.
    ir_in = 2'd1; sr = 38'h00_1234_5678; vs_udr = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step();
      chk("t3_take_no_action", p_tna, (e == 2) ? 4'b0010 : 4'b0000);
      chk("t3_take_action", p_ta, 4'b0000);
    end
    vs_udr = 1'b0; steps(4);

    // IR update, held level gives a single pulse.
    ir_in = 2'd3; vs_uir = 1'b1; pulses = 0;
    for (int e = 0; e < 8; e++) begin
      step();
      if (p_upd) pulses++;
      if (e == 2) begin
        chk("t4_ir_q", p_irq, 2'd3);
        chk("t4_update_ir", p_upd, 1'b1);
      end
    end
    chk("t4_single_pulse", pulses, 1);
    vs_uir = 1'b0; steps(4);

    // Simultaneous UIR and UDR: decode follows ir_in, not the old ir_q.
    ir_in = 2'd1; sr = 38'h04_0000_0001; vs_uir = 1'b1; vs_udr = 1'b1;
    steps(3);
    chk("same_cycle_take_action", p_ta, 4'b0010);
    chk("same_cycle_ir_q", p_irq, 2'd1);
    vs_uir = 1'b0; vs_udr = 1'b0; steps(4);

    // Handshake hold, then overrun while held.
    act_ready = 1'b0; ir_in = 2'd0; sr = 38'h04_0000_1234; vs_udr = 1'b1;
    steps(3);
    vs_udr = 1'b0;
    for (int e = 0; e < 20; e++) begin
      step();
      chk("t5_held_action", h_ta, 4'b0001);
      chk("t5_held_busy", h_busy, 1'b1);
    end
    sr = 38'h3F_FFFF_FFFF; ir_in = 2'd3; vs_udr = 1'b1;
    steps(3);
    vs_udr = 1'b0; steps(3);
    chk("t5_overrun", h_ovr, 1'b1);
    chk("t5_overrun_cnt", h_cnt, 2'd1);
    chk("t5_jdo_kept", h_jdo, 38'h04_0000_1234);
    chk("t5_action_kept", h_ta, 4'b0001);
    act_ready = 1'b1;
    step();
    chk("t5_release_action", h_ta, 4'b0000);
    chk("t5_release_busy", h_busy, 1'b0);
    act_ready = 1'b0;

    // Counter saturation and clear with a coinciding overrun.
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk("t6_cleared", h_cnt, 2'd0);
    ir_in = 2'd2; sr = 38'h00_0000_00AA; vs_udr = 1'b1; steps(3); vs_udr = 1'b0; steps(4);
    for (int k = 0; k < 5; k++) begin
      sr = SR_W'(k + 1); vs_udr = 1'b1; steps(3); vs_udr = 1'b0; steps(4);
    end
    chk("t6_saturated", h_cnt, 2'd3);
    chk("t6_jdo_kept", h_jdo, 38'h00_0000_00AA);
    vs_udr = 1'b1;
    steps(2);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("t6_clr_same_cycle_cnt", h_cnt, 2'd1);
    chk("t6_clr_same_cycle_ovr", h_ovr, 1'b1);
    vs_udr = 1'b0; steps(4);

    // Asynchronous reset while a command is held.
    chk("t1_pre_busy", h_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("t1_async_busy", h_busy, 1'b0);
    chk("t1_async_action", h_ta, 4'b0000);
    chk("t1_async_jdo", h_jdo, 38'h0);
    chk("t1_async_ovr", h_ovr, 1'b0);
    chk("t1_async_cnt", h_cnt, 2'd0);
    chk("t1_async_p_jdo", p_jdo, 38'h0);
    chk("t1_async_ir_q", p_irq, 2'd0);
    steps(2);
    reset_n = 1'b1;
    steps(2);
    chk("t1_busy_after_release", h_busy, 1'b0);

    // Randomised traffic against the model.
    udr_run = 0; uir_run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (udr_run == 0) begin vs_udr = ~vs_udr; udr_run = $urandom_range(1, 6); end
      if (uir_run == 0) begin vs_uir = ~vs_uir; uir_run = $urandom_range(1, 8); end
      udr_run--; uir_run--;
      ir_in       = IR_W'($urandom_range(0, 3));
      sr          = SR_W'({$urandom(), $urandom()});
      act_ready   = ($urandom_range(0, 3) == 0);
      clr_overrun = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
